divider: RTL

//  Sequential restoring divider, the inverse of the shift-add multiplier.

---
 rtl/divider_if.sv | 48 ++++
 rtl/divider.sv | 134 +++++++++++++
 2 files changed

// File: rtl/divider_if.sv
// divider_if: start/done handshake and operand/result bundle for the
// sequential divider.
//   master : drives start, dividend, divisor; observes results and status
//   slave  : the divider itself
//   start      1-cycle request
//   dividend   2*WIDTH-bit numerator
//   divisor    WIDTH-bit denominator
//   quotient   WIDTH-bit result, held until the next result
//   remainder  WIDTH-bit result, held until the next result
//   ovf        quotient does not fit in WIDTH bits (includes divisor==0)
//   busy       operation in progress (CALC or DONE)
//   done       1-cycle pulse when results update
//   div_zero   divide-by-zero flag, present only with DIVIDER_DIVZERO_EN
interface divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 ovf;
  logic                 busy;
  logic                 done;
`ifdef DIVIDER_DIVZERO_EN
  logic                 div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ovf, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ovf, busy, done, div_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ovf, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ovf, busy, done
  );
`endif
endinterface

// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. If the upper half
// of the dividend is >= the divisor the quotient cannot fit, so the result
// is reported immediately as overflow (quotient all ones, remainder 0).
// Otherwise WIDTH CALC cycles run, giving done W+1 edges after start.
// Ports:
//   clk      clock, all state changes on posedge
//   reset_n  asynchronous active-low reset
//   bus      divider_if slave: start/dividend/divisor in,
//            quotient/remainder/ovf/busy/done (and div_zero) out
// Optional feature macro: DIVIDER_DIVZERO_EN adds the div_zero output,
// set together with ovf when the divisor is zero.
module divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_d;
  logic             qbit_d;

  // Shift the next dividend bit into the partial remainder, then restore
  // (keep the trial value) when the divisor does not fit.
  always_comb begin
    trial  = (prem_q << 1) | {{WIDTH{1'b0}}, shift_q[WIDTH-1]};
    qbit_d = 1'b0;
    prem_d = trial;
    if (trial >= {1'b0, divisor_q}) begin
      qbit_d = 1'b1;
      prem_d = trial - {1'b0, divisor_q};
    end
  end

  // The shift register feeds dividend bits out of its MSB while quotient
  // bits enter at its LSB, so after WIDTH steps it holds the quotient.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prem_q      <= '0;
      shift_q     <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            divisor_q <= bus.divisor;
            busy_q    <= 1'b1;
            if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
              state_q     <= DONE;
              quotient_q  <= '1;
              remainder_q <= '0;
              ovf_q       <= 1'b1;
              div_zero_q  <= (bus.divisor == '0);
              done_q      <= 1'b1;
            end else begin
              state_q <= CALC;
              count_q <= '0;
              prem_q  <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
              shift_q <= bus.dividend[WIDTH-1:0];
            end
          end
        end
        CALC: begin
          prem_q  <= prem_d;
          shift_q <= {shift_q[WIDTH-2:0], qbit_d};
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            quotient_q  <= {shift_q[WIDTH-2:0], qbit_d};
            remainder_q <= prem_d[WIDTH-1:0];
            ovf_q       <= 1'b0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef DIVIDER_DIVZERO_EN
  assign bus.div_zero  = div_zero_q;
`else
  // Tracked regardless so the sequential block is identical in both builds.
  logic unused_div_zero;
  assign unused_div_zero = div_zero_q;
`endif

endmodule
